jk_mod_counter: RTL
===================

JK_MOD_COUNTER -- requirements
Module: jk_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL have parameter MOD, default 10, count modulus, legal range 2..2^WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clr  input  1  synchronous clear to 0.
REQ-006 SHALL have port load  input  1  synchronous load of load_val.
REQ-007 SHALL have port load_val  input  WIDTH  value to load.
REQ-008 SHALL have port en  input  1  count enable.
REQ-009 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-010 SHALL have port count  output  WIDTH  current count, taken directly from the flip-flop q outputs.
REQ-011 SHALL have port tc  output  1  terminal count, combinational.
REQ-012 SHALL have port wrap  output  1  registered one-cycle pulse after a wrap-around.

Function
REQ-013 SHALL hold state in WIDTH JK flip-flops; an excitation stage computes next state and drives j/k of each flip-flop.
REQ-014 SHALL drive excitation per bit: 0->1 gives J=1, K=0; 1->0 gives J=0, K=1; unchanged gives J=0, K=0 (hold); J=K=1 SHALL never be driven.
REQ-015 SHALL tie each flip-flop's set input to 0.
REQ-016 SHALL apply priority clr > load > en; with none asserted, count holds.
REQ-017 SHALL, on clr, make count 0 after the edge, regardless of load, en and up.
REQ-018 SHALL, on load with load_val < MOD, make count equal load_val after the edge.
REQ-019 SHALL, on load with load_val >= MOD, saturate count to MOD-1.
REQ-020 SHALL, with en=1 and up=1, increment; at count == MOD-1 it SHALL wrap to 0.
REQ-021 SHALL, with en=1 and up=0, decrement; at count == 0 it SHALL wrap to MOD-1.
REQ-022 SHALL assert tc = en & ((up & count == MOD-1) | (~up & count == 0)).
REQ-023 SHALL register wrap = tc & ~clr & ~load, so wrap is high for exactly the one cycle after a wrap edge.
REQ-024 SHALL have a latency of one clock from any control input to count.
REQ-025 SHALL show no change to count on a direction change mid-count; the new direction takes effect on the next enabled edge.
REQ-026 SHALL, if count somehow holds a value >= MOD (not reachable from reset), make the next enabled edge load 0 when up=1 and MOD-1 when up=0.

Reset
REQ-027 SHALL, on rst_n low, immediately force count = 0 and wrap = 0, independent of clk, via each flip-flop's rst_n.
REQ-028 SHALL, after rst_n rises, resume normal operation from the first rising clk edge; a reset asserted mid-count SHALL discard the in-progress value.

Structure
REQ-029 SHALL place in shared package jk_pkg: enum jk_cmd_t {JK_HOLD, JK_RESET, JK_SET, JK_TOGGLE} and function jk_excite(q, q_next) returning the {j,k} pair.
REQ-030 SHALL instantiate the existing JKFF cell once per bit via a generate loop.
REQ-031 SHALL implement next-state and excitation in one sub-module, jk_mod_next (pure combinational), separate from the flip-flop bank.

Verification
REQ-032 Reset: rst_n=0 for 5 ns mid-count at count=7 -> count=0 and wrap=0 immediately, before any clk edge.
REQ-033 Up wrap (MOD=10): en=1, up=1 for 12 edges from 0 -> count 1..9, 0, 1, 2; tc high while count=9; wrap high for one cycle when count=0.
REQ-034 Down wrap: load_val=1 loaded, then en=1, up=0 -> count 0, 9, 8; tc high at count 0; wrap pulses once.
REQ-035 Priority: clr=1, load=1, load_val=5, en=1 on the same edge -> count=0, wrap=0; next edge with load only -> count=5.
REQ-036 Load saturation: load_val=13 with MOD=10 -> count=9; en=0 for 3 edges -> count stays 9 and tc=0.
REQ-037 Excitation check: every edge of REQ-033, probe j/k on all bits -> (1,1) never occurs; (0,0) on every bit whose value is unchanged.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions: command encoding and the excitation
// function that maps a desired q -> q_next transition onto a {j,k} pair.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_t;

  // Toggle is deliberately never produced: each transition uses a one-sided command.
  function automatic logic [1:0] jk_excite(input logic q, input logic q_next);
    logic [1:0] jk_s;
    case ({q, q_next})
      2'b01:   jk_s = JK_SET;
      2'b10:   jk_s = JK_RESET;
      default: jk_s = JK_HOLD;
    endcase
    return jk_s;
  endfunction

endpackage

// File: rtl/jk_mod_next.sv
// Combinational next-state and JK excitation for the modulo counter,
// plus the terminal-count flag.
module jk_mod_next
  import jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic [WIDTH-1:0] count,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             tc
);

  // The modulus may equal 2^WIDTH, so compare against it one bit wider
  localparam logic [WIDTH:0]   MOD_L = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  logic [WIDTH-1:0] nxt_s;
  logic [1:0]       jk_s;

  // Next-state selection with clr > load > en priority
  always_comb begin
    nxt_s = count;
    if (clr) begin
      nxt_s = '0;
    end else if (load) begin
      if ({1'b0, load_val} < MOD_L) begin
        nxt_s = load_val;
      end else begin
        nxt_s = MAX_C;
      end
    end else if (en) begin
      if (up) begin
        // Out-of-range values recover to 0 just like a normal wrap
        if (count >= MAX_C) begin
          nxt_s = '0;
        end else begin
          nxt_s = count + ONE_C;
        end
      end else begin
        if ((count == '0) || (count > MAX_C)) begin
          nxt_s = MAX_C;
        end else begin
          nxt_s = count - ONE_C;
        end
      end
    end else begin
      nxt_s = count;
    end
  end

  // Per-bit excitation derived from the q -> q_next transition
  always_comb begin
    j    = '0;
    k    = '0;
    jk_s = 2'b00;
    for (int i = 0; i < WIDTH; i++) begin
      jk_s = jk_excite(count[i], nxt_s[i]);
      j[i] = jk_s[1];
      k[i] = jk_s[0];
    end
  end

  assign tc = en & ((up & (count == MAX_C)) | (~up & (count == '0)));

endmodule

// File: rtl/jkff.sv
// JK flip-flop cell with asynchronous active-low reset and synchronous set.
module jkff
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_r;

  // JK state update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= 1'b0;
    end else if (set) begin
      q_r <= 1'b1;
    end else begin
      case (jk_cmd_t'({j, k}))
        JK_HOLD:   q_r <= q_r;
        JK_RESET:  q_r <= 1'b0;
        JK_SET:    q_r <= 1'b1;
        JK_TOGGLE: q_r <= ~q_r;
        default:   q_r <= q_r;
      endcase
    end
  end

  assign q = q_r;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter built from a bank of JK flip-flops, with
// synchronous clear/load, combinational terminal count and registered wrap pulse.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_s;
  logic             tc_s;
  logic             wrap_r;

  jk_mod_next #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_next (
    .count    (q_s),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .up       (up),
    .j        (j_s),
    .k        (k_s),
    .tc       (tc_s)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_ff
    jkff u_ff (
      .clk   (clk),
      .rst_n (rst_n),
      .set   (1'b0),
      .j     (j_s[i]),
      .k     (k_s[i]),
      .q     (q_s[i])
    );
  end

  // Wrap pulse: terminal count that was not overridden by clr or load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= tc_s & ~clr & ~load;
    end
  end

  assign count = q_s;
  assign tc    = tc_s;
  assign wrap  = wrap_r;

endmodule
